// File: rtl/seven_seg_if.sv
// seven_seg_if: display data/control inputs and scanned segment outputs
interface seven_seg_if #(parameter int NUM_DIGITS = 4);
  logic [4*NUM_DIGITS-1:0] digits_in;
  logic [NUM_DIGITS-1:0] dp_in;
  logic load;
  logic enable;
  logic [6:0] seg;
  logic dp;
  logic [NUM_DIGITS-1:0] an;
  logic frame_done;
  modport master(output digits_in, dp_in, load, enable, input seg, dp, an, frame_done);
  modport slave(input digits_in, dp_in, load, enable, output seg, dp, an, frame_done);
endinterface

// File: rtl/seven_seg_scan_driver.sv
// seven_seg_scan_driver: time-multiplexed N-digit 7-segment driver with frame-synchronous updates
module seven_seg_scan_driver #(
  parameter int NUM_DIGITS = 4,
  parameter int REFRESH_DIV = 50000,
  parameter int HEX_MODE = 0,
  parameter int ACTIVE_LOW = 1,
  parameter int LZ_SUPPRESS = 1
) (
  input logic clk,
  input logic rst,
  seven_seg_if.slave bus
);
  localparam int IW = NUM_DIGITS > 1 ? $clog2(NUM_DIGITS) : 1;
  localparam int PW = $clog2(REFRESH_DIV);
  localparam logic AL = ACTIVE_LOW != 0;
  localparam logic [6:0] DEC [16] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                                      7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};
  logic [PW-1:0] presc;
  logic [IW-1:0] idx;
  logic [4*NUM_DIGITS-1:0] pend_d, act_d;
  logic [NUM_DIGITS-1:0] pend_dp, act_dp;
  logic tc, wrap, nz_hi, blank, cur_dp;
  logic [3:0] code;
  logic [6:0] seg_on;
  logic [NUM_DIGITS-1:0] onehot;
  // select the current digit, work out leading-zero blanking and decode it
  always_comb begin
    tc = presc == PW'(REFRESH_DIV - 1);
    wrap = bus.enable && tc && idx == IW'(NUM_DIGITS - 1);
    code = '0;
    cur_dp = 1'b0;
    nz_hi = 1'b0;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      code = idx == IW'(i) ? act_d[4*i +: 4] : code;
      cur_dp = idx == IW'(i) ? act_dp[i] : cur_dp;
      nz_hi = nz_hi | (i >= int'(idx) && act_d[4*i +: 4] != 4'd0);
    end
    blank = LZ_SUPPRESS != 0 && idx != '0 && !nz_hi;
    seg_on = (blank || (HEX_MODE == 0 && code > 4'd9)) ? 7'd0 : DEC[code];
    onehot = NUM_DIGITS'(1) << idx;
  end
  // scan counters, pending/active double buffer and registered pin outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      presc <= '0;
      idx <= '0;
      pend_d <= '0;
      pend_dp <= '0;
      act_d <= '0;
      act_dp <= '0;
      bus.seg <= {7{AL}};
      bus.dp <= AL;
      bus.an <= {NUM_DIGITS{AL}};
      bus.frame_done <= 1'b0;
    end else begin
      if (bus.enable) begin
        presc <= tc ? '0 : presc + PW'(1);
        if (tc) idx <= idx == IW'(NUM_DIGITS - 1) ? '0 : idx + IW'(1);
      end
      if (bus.load) begin
        pend_d <= bus.digits_in;
        pend_dp <= bus.dp_in;
      end
      if (wrap) begin
        act_d <= bus.load ? bus.digits_in : pend_d;
        act_dp <= bus.load ? bus.dp_in : pend_dp;
      end
      bus.frame_done <= wrap;
      bus.seg <= bus.enable ? seg_on ^ {7{AL}} : {7{AL}};
      bus.dp <= bus.enable ? cur_dp ^ AL : AL;
      bus.an <= bus.enable ? onehot ^ {NUM_DIGITS{AL}} : {NUM_DIGITS{AL}};
    end
  end
endmodule

// File: tb/tb_seven_seg_scan_driver.sv
// tb_seven_seg_scan_driver: scoreboard bench for the scan driver (HEX_MODE 0 and 1 in lockstep)
module tb_seven_seg_scan_driver;
  typedef struct {
    logic [3:0] an;
    logic [6:0] seg;
    logic dp;
  } exp_t;
  logic clk = 1'b0;
  logic rst, load, enable;
  logic [15:0] digits;
  logic [3:0] dpv;
  int checks = 0;
  int errors = 0;
  exp_t q[$];
  logic [6:0] dec [16] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                           7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};
  seven_seg_if #(.NUM_DIGITS(4)) b0 ();
  seven_seg_if #(.NUM_DIGITS(4)) b1 ();
  assign b0.digits_in = digits;
  assign b0.dp_in = dpv;
  assign b0.load = load;
  assign b0.enable = enable;
  assign b1.digits_in = digits;
  assign b1.dp_in = dpv;
  assign b1.load = load;
  assign b1.enable = enable;
  seven_seg_scan_driver #(.NUM_DIGITS(4), .REFRESH_DIV(4), .HEX_MODE(0), .ACTIVE_LOW(1), .LZ_SUPPRESS(1))
    dut0 (.clk(clk), .rst(rst), .bus(b0));
  seven_seg_scan_driver #(.NUM_DIGITS(4), .REFRESH_DIV(4), .HEX_MODE(1), .ACTIVE_LOW(1), .LZ_SUPPRESS(1))
    dut1 (.clk(clk), .rst(rst), .bus(b1));
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_load(input logic [15:0] v, input logic [3:0] d);
    digits = v;
    dpv = d;
    load = 1'b1;
    tick();
    load = 1'b0;
  endtask

  task automatic push_frame(input logic [15:0] v, input logic [3:0] d, input bit hex);
    for (int i = 0; i < 4; i++) begin
      logic [3:0] c;
      logic [15:0] hi;
      logic [6:0] s;
      c = v[4*i +: 4];
      hi = v >> (4 * i);
      s = ((i > 0 && hi == 16'd0) || (!hex && c > 4'd9)) ? 7'd0 : dec[c];
      q.push_back('{~(4'b0001 << i), ~s, ~d[i]});
    end
  endtask

  task automatic wait_an(input logic [3:0] target, output bit seen);
    seen = 1'b0;
    for (int i = 0; i < 100 && !seen; i++) begin
      tick();
      seen = b0.an == target;
    end
  endtask

  task automatic check_frame(input bit hex, input bit mid, input logic [15:0] mv, input logic [3:0] mdp);
    bit seen;
    exp_t e;
    seen = 1'b0;
    for (int i = 0; i < 100 && !seen; i++) begin
      tick();
      seen = b0.frame_done;
    end
    chk("frame_wait", 16'(seen), 16'd1);
    for (int k = 0; k < 16; k++) begin
      tick();
      chk("an_onehot", 16'($countones(~(hex ? b1.an : b0.an))), 16'd1);
      if (k % 4 == 0) begin
        e = q.pop_front();
        chk($sformatf("an_slot%0d", k / 4), 16'(hex ? b1.an : b0.an), 16'(e.an));
        chk($sformatf("seg_slot%0d", k / 4), 16'(hex ? b1.seg : b0.seg), 16'(e.seg));
        chk($sformatf("dp_slot%0d", k / 4), 16'(hex ? b1.dp : b0.dp), 16'(e.dp));
      end
      if (mid && k == 2) begin
        digits = mv;
        dpv = mdp;
        load = 1'b1;
      end else load = 1'b0;
    end
  endtask

  initial begin
    bit seen;
    int n;
    rst = 1'b1;
    load = 1'b0;
    enable = 1'b0;
    digits = '0;
    dpv = '0;
    repeat (3) tick();
    chk("rst_an", 16'(b0.an), 16'hF);
    chk("rst_seg", 16'(b0.seg), 16'h7F);
    chk("rst_dp", 16'(b0.dp), 16'h1);
    chk("rst_fd", 16'(b0.frame_done), 16'h0);
    rst = 1'b0;
    enable = 1'b1;
    do_load(16'h1234, 4'b0101);
    push_frame(16'h1234, 4'b0101, 1'b0);
    check_frame(1'b0, 1'b0, 16'h0, 4'h0);
    push_frame(16'h1234, 4'b0101, 1'b0);
    check_frame(1'b0, 1'b1, 16'h5555, 4'h0);
    push_frame(16'h5555, 4'h0, 1'b0);
    check_frame(1'b0, 1'b0, 16'h0, 4'h0);
    do_load(16'h0070, 4'b1000);
    push_frame(16'h0070, 4'b1000, 1'b0);
    check_frame(1'b0, 1'b0, 16'h0, 4'h0);
    do_load(16'h00A0, 4'h0);
    push_frame(16'h00A0, 4'h0, 1'b0);
    check_frame(1'b0, 1'b0, 16'h0, 4'h0);
    push_frame(16'h00A0, 4'h0, 1'b1);
    check_frame(1'b1, 1'b0, 16'h0, 4'h0);
    do_load(16'hFEDC, 4'b0010);
    push_frame(16'hFEDC, 4'b0010, 1'b1);
    check_frame(1'b1, 1'b0, 16'h0, 4'h0);
    chk("queue_empty", 16'(q.size()), 16'd0);
    seen = 1'b0;
    for (int i = 0; i < 100 && !seen; i++) begin
      tick();
      seen = b0.frame_done;
    end
    n = 0;
    do begin
      tick();
      n++;
    end while (!b0.frame_done && n < 100);
    chk("frame_period", 16'(n), 16'd16);
    wait_an(4'b1101, seen);
    chk("wait_digit1", 16'(seen), 16'd1);
    enable = 1'b0;
    tick();
    chk("dis_an", 16'(b0.an), 16'hF);
    chk("dis_seg", 16'(b0.seg), 16'h7F);
    chk("dis_dp", 16'(b0.dp), 16'h1);
    repeat (9) tick();
    chk("dis_hold_an", 16'(b0.an), 16'hF);
    enable = 1'b1;
    tick();
    chk("resume_an", 16'(b0.an), 16'hD);
    wait_an(4'b1011, seen);
    chk("wait_digit2", 16'(seen), 16'd1);
    rst = 1'b1;
    tick();
    chk("midrst_an", 16'(b0.an), 16'hF);
    chk("midrst_seg", 16'(b0.seg), 16'h7F);
    chk("midrst_fd", 16'(b0.frame_done), 16'h0);
    rst = 1'b0;
    tick();
    chk("post_rst_an", 16'(b0.an), 16'hE);
    chk("post_rst_seg", 16'(b0.seg), 16'h40);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
